// File: rtl/hack_memory_if.sv
// CPU data bus and display read port of the Hack data-memory stage.
// The memory is the slave; the CPU/display side is the master.
interface hack_memory_if;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic        disp_ready;
    logic        disp_valid;
    logic [15:0] disp_data;

    modport master (
        output addressM, outM, writeM, disp_req, disp_addr,
        input  inM, disp_ready, disp_valid, disp_data
    );

    modport slave (
        input  addressM, outM, writeM, disp_req, disp_addr,
        output inM, disp_ready, disp_valid, disp_data
    );
endinterface

// File: rtl/hack_memory.sv
// Hack data memory: RAM, screen buffer, keyboard register and an arbitrated display read port.
// Optional HACK_MEM_BOUNDS_TRAP_EN adds a sticky mem_fault flag for writes to KBD/unmapped space.
module hack_memory #(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter int unsigned SCREEN_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset,
    hack_memory_if.slave      bus,
    input  logic [15:0]       kbd_data,
    input  logic              kbd_valid,
    output logic              mem_fault
);
    localparam int unsigned RamAw = $clog2(RAM_WORDS);
    localparam int unsigned ScrAw = $clog2(SCREEN_WORDS);

    typedef enum logic {StIdle, StPend} state_e;

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] screen [SCREEN_WORDS];

    state_e             state_q, state_d;
    logic [ScrAw-1:0]   pend_addr_q;
    logic [15:0]        kbd_q;
    logic               disp_valid_q;
    logic [15:0]        disp_data_q;

    logic               ram_sel, scr_sel, kbd_sel;
    logic [RamAw-1:0]   ram_idx;
    logic [ScrAw-1:0]   scr_idx;
    logic [ScrAw-1:0]   rd_idx;
    logic               scr_wr, disp_accept, disp_rd, disp_ready;

    assign ram_sel = (bus.addressM[15:14] == 2'b00);
    assign scr_sel = (bus.addressM[15:13] == 3'b010);
    assign kbd_sel = (bus.addressM == 16'h6000);
    assign ram_idx = bus.addressM[RamAw-1:0];
    assign scr_idx = bus.addressM[ScrAw-1:0];

    assign scr_wr      = bus.writeM && scr_sel;
    assign disp_accept = bus.disp_req && disp_ready;
    assign rd_idx      = (state_q == StPend) ? pend_addr_q : bus.disp_addr[ScrAw-1:0];

    // Memories have no reset; reset only suppresses writes.
    always_ff @(posedge clk) begin
        if (!reset && bus.writeM && ram_sel) begin
            ram[ram_idx] <= bus.outM;
        end
        if (!reset && scr_wr) begin
            screen[scr_idx] <= bus.outM;
        end
    end

    always_comb begin
        bus.inM = 16'h0000;
        if (ram_sel) begin
            bus.inM = ram[ram_idx];
        end else if (scr_sel) begin
            bus.inM = screen[scr_idx];
        end else if (kbd_sel) begin
            bus.inM = kbd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A display read never shares an edge with a CPU screen write, so it always sees post-write data.
    always_comb begin
        state_d = state_q;
        disp_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (disp_accept && scr_wr) begin
                    state_d = StPend;
                end else if (disp_accept) begin
                    disp_rd = 1'b1;
                end
            end
            StPend: begin
                if (!scr_wr) begin
                    state_d = StIdle;
                    disp_rd = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        disp_ready = (state_q == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_addr_q  <= '0;
            kbd_q        <= 16'h0000;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 16'h0000;
        end else begin
            if (kbd_valid) begin
                kbd_q <= kbd_data;
            end
            if (state_q == StIdle && disp_accept) begin
                pend_addr_q <= bus.disp_addr[ScrAw-1:0];
            end
            disp_valid_q <= disp_rd;
            if (disp_rd) begin
                disp_data_q <= screen[rd_idx];
            end
        end
    end

    assign bus.disp_ready = disp_ready;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;

`ifdef HACK_MEM_BOUNDS_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (bus.writeM && !ram_sel && !scr_sel) begin
            fault_q <= 1'b1;
        end
    end

    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif
endmodule

// File: tb/tb_hack_memory.sv
// Directed self-checking bench for hack_memory.
module tb_hack_memory;
    logic        clk;
    logic        reset;
    logic [15:0] kbd_data;
    logic        kbd_valid;
    logic        mem_fault;
    int          n_checks;
    int          n_fail;

    hack_memory_if bus();

    hack_memory dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .mem_fault (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
        bus.addressM = addr;
        bus.outM     = data;
        bus.writeM   = 1'b1;
        cycle();
        bus.writeM   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        bus.addressM = 16'h6000;
        #1;
        n_checks++;
        if (bus.disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_disp_valid: got %b expected 0", bus.disp_valid);
        end
        n_checks++;
        if (bus.disp_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_disp_data: got %h expected 0000", bus.disp_data);
        end
        n_checks++;
        if (bus.disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_disp_ready: got %b expected 1", bus.disp_ready);
        end
        n_checks++;
        if (mem_fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_fault: got %b expected 0", mem_fault);
        end
        n_checks++;
        if (bus.inM !== 16'h0000) begin
            n_fail++; $display("FAIL reset_kbd: got %h expected 0000", bus.inM);
        end
        reset = 1'b0;
    endtask

    task automatic test_ram_screen_rw();
        cpu_write(16'h0005, 16'h1234);
        bus.addressM = 16'h0005;
        #1;
        n_checks++;
        if (bus.inM !== 16'h1234) begin
            n_fail++; $display("FAIL rd_ram_0005: got %h expected 1234", bus.inM);
        end
        cpu_write(16'h5FFF, 16'hBEEF);
        #1;
        n_checks++;
        if (bus.inM !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_scr_5fff: got %h expected beef", bus.inM);
        end
        bus.addressM = 16'h0005;
        #1;
        n_checks++;
        if (bus.inM !== 16'h1234) begin
            n_fail++; $display("FAIL rd_ram_0005_again: got %h expected 1234", bus.inM);
        end
        bus.addressM = 16'h7000;
        #1;
        n_checks++;
        if (bus.inM !== 16'h0000) begin
            n_fail++; $display("FAIL rd_unmapped_7000: got %h expected 0000", bus.inM);
        end
        cpu_write(16'h3FFF, 16'hC0DE);
        #1;
        n_checks++;
        if (bus.inM !== 16'hC0DE) begin
            n_fail++; $display("FAIL rd_ram_3fff: got %h expected c0de", bus.inM);
        end
    endtask

    task automatic test_kbd();
        kbd_data  = 16'h0041;
        kbd_valid = 1'b1;
        cycle();
        kbd_valid = 1'b0;
        kbd_data  = 16'h0099;
        bus.addressM = 16'h6000;
        #1;
        n_checks++;
        if (bus.inM !== 16'h0041) begin
            n_fail++; $display("FAIL kbd_load: got %h expected 0041", bus.inM);
        end
        cycle();
        n_checks++;
        if (bus.inM !== 16'h0041) begin
            n_fail++; $display("FAIL kbd_hold: got %h expected 0041", bus.inM);
        end
        cpu_write(16'h6000, 16'hFFFF);
        n_checks++;
        if (bus.inM !== 16'h0041) begin
            n_fail++; $display("FAIL kbd_write_dropped: got %h expected 0041", bus.inM);
        end
        kbd_data  = 16'h0000;
        kbd_valid = 1'b1;
        cycle();
        kbd_valid = 1'b0;
        n_checks++;
        if (bus.inM !== 16'h0000) begin
            n_fail++; $display("FAIL kbd_release: got %h expected 0000", bus.inM);
        end
    endtask

    task automatic test_disp_simple();
        cpu_write(16'h4010, 16'hAAAA);
        bus.disp_addr = 13'h0010;
        bus.disp_req  = 1'b1;
        n_checks++;
        if (bus.disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL disp_simple_ready_pre: got %b expected 1", bus.disp_ready);
        end
        cycle();
        bus.disp_req = 1'b0;
        n_checks++;
        if (bus.disp_valid !== 1'b1) begin
            n_fail++; $display("FAIL disp_simple_valid: got %b expected 1", bus.disp_valid);
        end
        n_checks++;
        if (bus.disp_data !== 16'hAAAA) begin
            n_fail++; $display("FAIL disp_simple_data: got %h expected aaaa", bus.disp_data);
        end
        n_checks++;
        if (bus.disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL disp_simple_ready_post: got %b expected 1", bus.disp_ready);
        end
        cycle();
        n_checks++;
        if (bus.disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL disp_simple_pulse: got %b expected 0", bus.disp_valid);
        end
        n_checks++;
        if (bus.disp_data !== 16'hAAAA) begin
            n_fail++; $display("FAIL disp_simple_hold: got %h expected aaaa", bus.disp_data);
        end
    endtask

    task automatic test_disp_conflict();
        logic [15:0] wr_addr [3];
        logic [15:0] wr_data [3];
        wr_addr = '{16'h4010, 16'h4011, 16'h4012};
        wr_data = '{16'h5555, 16'h1111, 16'h2222};
        bus.disp_addr = 13'h0010;
        bus.disp_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addressM = wr_addr[i];
            bus.outM     = wr_data[i];
            bus.writeM   = 1'b1;
            cycle();
            bus.disp_req = 1'b0;
            n_checks++;
            if (bus.disp_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL disp_conflict_ready_%0d: got %b expected 0", i, bus.disp_ready);
            end
            n_checks++;
            if (bus.disp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL disp_conflict_early_valid_%0d: got %b expected 0", i,
                         bus.disp_valid);
            end
        end
        bus.writeM = 1'b0;
        cycle();
        n_checks++;
        if (bus.disp_valid !== 1'b1) begin
            n_fail++; $display("FAIL disp_conflict_valid: got %b expected 1", bus.disp_valid);
        end
        n_checks++;
        if (bus.disp_data !== 16'h5555) begin
            n_fail++; $display("FAIL disp_conflict_data: got %h expected 5555", bus.disp_data);
        end
        n_checks++;
        if (bus.disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL disp_conflict_ready_back: got %b expected 1", bus.disp_ready);
        end
        cycle();
        n_checks++;
        if (bus.disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL disp_conflict_pulse: got %b expected 0", bus.disp_valid);
        end
    endtask

    task automatic test_fault();
        logic exp_fault;
`ifdef HACK_MEM_BOUNDS_TRAP_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (mem_fault !== 1'b0) begin
            n_fail++; $display("FAIL fault_cleared: got %b expected 0", mem_fault);
        end
        cpu_write(16'h8000, 16'h1234);
        n_checks++;
        if (mem_fault !== exp_fault) begin
            n_fail++; $display("FAIL fault_set: got %b expected %b", mem_fault, exp_fault);
        end
        cycle();
        cycle();
        n_checks++;
        if (mem_fault !== exp_fault) begin
            n_fail++; $display("FAIL fault_sticky: got %b expected %b", mem_fault, exp_fault);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (mem_fault !== 1'b0) begin
            n_fail++; $display("FAIL fault_reset: got %b expected 0", mem_fault);
        end
    endtask

    task automatic test_reset_priority();
        cpu_write(16'h0001, 16'h0007);
        cpu_write(16'h4020, 16'h9999);
        reset         = 1'b1;
        bus.addressM  = 16'h0001;
        bus.outM      = 16'hFFFF;
        bus.writeM    = 1'b1;
        kbd_data      = 16'h0055;
        kbd_valid     = 1'b1;
        bus.disp_addr = 13'h0020;
        bus.disp_req  = 1'b1;
        cycle();
        n_checks++;
        if (bus.disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstprio_valid_0: got %b expected 0", bus.disp_valid);
        end
        reset        = 1'b0;
        bus.writeM   = 1'b0;
        kbd_valid    = 1'b0;
        bus.disp_req = 1'b0;
        #1;
        n_checks++;
        if (bus.inM !== 16'h0007) begin
            n_fail++; $display("FAIL rstprio_ram: got %h expected 0007", bus.inM);
        end
        cycle();
        n_checks++;
        if (bus.disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstprio_valid_1: got %b expected 0", bus.disp_valid);
        end
        n_checks++;
        if (bus.disp_data !== 16'h0000) begin
            n_fail++; $display("FAIL rstprio_data: got %h expected 0000", bus.disp_data);
        end
        bus.addressM = 16'h6000;
        #1;
        n_checks++;
        if (bus.inM !== 16'h0000) begin
            n_fail++; $display("FAIL rstprio_kbd: got %h expected 0000", bus.inM);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        kbd_data      = 16'h0000;
        kbd_valid     = 1'b0;
        bus.addressM  = 16'h0000;
        bus.outM      = 16'h0000;
        bus.writeM    = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = 13'h0000;

        test_reset();
        test_ram_screen_rw();
        test_kbd();
        test_disp_simple();
        test_disp_conflict();
        test_fault();
        test_reset_priority();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
